pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Sequences the board PLL (new_pll / EHXPLLL) after power-up and after lock loss.
//  - Drives the PLL RST input.
//  - Qualifies LOCK: it must stay high for a stable window before the block releases the downstream reset.
//  - Retries PLL reset on lock timeout and goes to a sticky fault after repeated failures.
//  - Runs on the free-running 25 MHz input clock, never on the PLL output.
//  - The consumer re-synchronises reset_out into the PLL clock domain.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT   65536  cycles allowed in WAIT_LOCK before a retry (>=2)
//  STABLE_CYCLES  1024   consecutive locked cycles required before RUN (>=1)
//  MAX_RETRIES    8      lock-timeout retries before FAULT; 0 = retry forever
//  COUNT_WIDTH    8      width of the retry and lock-loss counters
// PORTS
//  clock_in         in   1            25 MHz reference clock, sole clock
//  reset            in   1            synchronous, active-high
//  locked           in   1            PLL LOCK, asynchronous to clock_in
//  relock_req       in   1            single-cycle pulse: force a PLL reset sequence
//  pll_rst          out  1            to EHXPLLL RST; 1 = PLL held in reset
//  reset_out        out  1            downstream reset; 1 = design held in reset
//  ready            out  1            1 only in RUN
//  fault            out  1            1 only in FAULT
//  state            out  3            current state code (debug)
//  retry_count      out  COUNT_WIDTH  lock timeouts since last RUN entry, saturating
//  lock_loss_count  out  COUNT_WIDTH  lock drops seen while in RUN since reset, saturating
// BEHAVIOUR
//  - Sync: locked passes a 2-FF synchroniser to locked_s (2-cycle latency). The FSM uses only locked_s.
//  - Outputs decode the registered state combinationally. They change the cycle the new state is entered.
//  - Reset: state=RESET_PLL, timer=0, both counters=0, synchroniser=0.
//    Outputs: pll_rst=1, reset_out=1, ready=0, fault=0.
//  - States: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT; codes 5-7 go to RESET_PLL.
//  - Timer: one shared up-counter of $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1) bits.
//    It clears on every state change.
//  - RESET_PLL: pll_rst=1, reset_out=1. Exits to WAIT_LOCK when timer==RST_CYCLES-1.
//  - WAIT_LOCK: pll_rst=0, reset_out=1.
//    - locked_s=1 goes to STABILIZE.
//    - Otherwise, at timer==LOCK_TIMEOUT-1: retry_count += 1 (saturating).
//      If MAX_RETRIES!=0 and the new count >= MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
//  - STABILIZE: pll_rst=0, reset_out=1.
//    - locked_s=0 returns to WAIT_LOCK with the timer cleared; the full LOCK_TIMEOUT restarts.
//    - At timer==STABLE_CYCLES-1 with locked_s=1, go to RUN.
//  - RUN: pll_rst=0, reset_out=0, ready=1. retry_count clears on entry.
//    locked_s=0 increments lock_loss_count (saturating at all-ones) and goes to RESET_PLL.
//  - FAULT: pll_rst=1, reset_out=1, fault=1. Sticky; exited only by reset or relock_req.
//  - relock_req: highest priority after reset.
//    - In any state it goes to RESET_PLL with the timer cleared.
//    - In FAULT it also clears retry_count.
//    - When it coincides with a RUN lock drop, lock_loss_count is NOT incremented.
//    - During RESET_PLL it restarts the RST_CYCLES window.
//  - Reset mid-sequence aborts immediately to the reset values; counters clear.
//  - Latency: a locked rise at cycle t gives RUN (reset_out=0) at t+3+STABLE_CYCLES, provided WAIT_LOCK is already active.
// TESTING (bench params: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3)
//  1. Release reset at cycle 0, locked=0.
//     -> pll_rst=1 for cycles 0-3; WAIT_LOCK at cycle 4.
//     Raise locked at cycle 10 -> reset_out falls and ready rises at cycle 21.
//  2. Lock glitch: locked high cycles 10-14, low 15-16, then high.
//     -> STABILIZE aborts to WAIT_LOCK; RUN entered 11 cycles after the cycle-17 rise; lock_loss_count=0.
//  3. locked held 0 -> retry_count 1, 2, 3 at each 32-cycle timeout.
//     -> FAULT after the third timeout: fault=1, pll_rst=1.
//     relock_req pulse -> retry_count=0, state=RESET_PLL.
//  4. In RUN, drop locked for 1 cycle.
//     -> reset_out=1 and pll_rst=1 two cycles after the drop; lock_loss_count=1; a full resequence then reaches RUN.
//  5. COUNT_WIDTH=2, five RUN lock drops -> lock_loss_count saturates at 3.
//  6. In RUN, relock_req in the same cycle locked_s falls.
//     -> RESET_PLL next cycle, lock_loss_count unchanged.
//     Assert reset during STABILIZE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier for the EHXPLLL.
// Runs on the free-running reference clock; reset_out is resynced by the consumer.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   relock_req,
  output logic                   pll_rst,
  output logic                   reset_out,
  output logic                   ready,
  output logic                   fault,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retry_count,
  output logic [COUNT_WIDTH-1:0] lock_loss_count
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ?
                         RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T = (MAX_A > STABLE_CYCLES) ?
                         MAX_A : STABLE_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] T_RST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LT  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ST  = TW'(STABLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                 st;
  state_t                 st_nx;
  logic [TW-1:0]          timer;
  logic                   tmr_clr;
  logic                   lk_meta;
  logic                   locked_s;
  logic [COUNT_WIDTH-1:0] retry_nx;
  logic [COUNT_WIDTH-1:0] loss_nx;
  logic [COUNT_WIDTH-1:0] retry_inc;
  logic [COUNT_WIDTH-1:0] loss_inc;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      lk_meta  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      lk_meta  <= locked;
      locked_s <= lk_meta;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      st              <= S_RESET_PLL;
      timer           <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      st              <= st_nx;
      timer           <= tmr_clr ? '0 : timer + 1'b1;
      retry_count     <= retry_nx;
      lock_loss_count <= loss_nx;
    end
  end

  assign retry_inc = (retry_count == CMAX) ?
                     retry_count : retry_count + 1'b1;
  assign loss_inc  = (lock_loss_count == CMAX) ?
                     lock_loss_count : lock_loss_count + 1'b1;

  always_comb begin
    st_nx    = st;
    retry_nx = retry_count;
    loss_nx  = lock_loss_count;
    tmr_clr  = 1'b0;
    if (relock_req) begin
      st_nx   = S_RESET_PLL;
      tmr_clr = 1'b1;
      if (st == S_FAULT) retry_nx = '0;
    end else begin
      unique case (st)
        S_RESET_PLL: begin
          if (timer == T_RST) st_nx = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            st_nx = S_STABILIZE;
          end else if (timer == T_LT) begin
            retry_nx = retry_inc;
            if (MAX_RETRIES != 0 &&
                32'(retry_inc) >= 32'(MAX_RETRIES))
              st_nx = S_FAULT;
            else
              st_nx = S_RESET_PLL;
          end
        end
        S_STABILIZE: begin
          if (!locked_s) begin
            st_nx = S_WAIT_LOCK;
          end else if (timer == T_ST) begin
            st_nx    = S_RUN;
            retry_nx = '0;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            st_nx   = S_RESET_PLL;
            loss_nx = loss_inc;
          end
        end
        S_FAULT: begin
          st_nx = S_FAULT;
        end
        default: begin
          st_nx = S_RESET_PLL;
        end
      endcase
    end
    // STABILIZE -> WAIT_LOCK also lands here, restarting the full timeout
    if (st_nx != st) tmr_clr = 1'b1;
  end

  always_comb begin
    pll_rst   = 1'b1;
    reset_out = 1'b1;
    ready     = 1'b0;
    fault     = 1'b0;
    unique case (st)
      S_WAIT_LOCK,
      S_STABILIZE: pll_rst = 1'b0;
      S_RUN: begin
        pll_rst   = 1'b0;
        reset_out = 1'b0;
        ready     = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: directed scenarios plus
// randomized lock/relock/reset traffic against a phase/elapsed-time model.
module tb_pll_lock_supervisor;

  localparam int R    = 4;
  localparam int LT   = 32;
  localparam int ST   = 8;
  localparam int MR   = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int OW   = 7 + 2 * CW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic          reset_out;
  logic          ready;
  logic          fault;
  logic [2:0]    state;
  logic [CW-1:0] retry_count;
  logic [CW-1:0] lock_loss_count;

  always #20 clk = ~clk;

  pll_lock_supervisor #(
    .RST_CYCLES   (R),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(ST),
    .MAX_RETRIES  (MR),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock_in       (clk),
    .reset          (reset),
    .locked         (locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .reset_out      (reset_out),
    .ready          (ready),
    .fault          (fault),
    .state          (state),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] expq[$];
  bit done  = 0;
  bit armed = 0;

  // model: phase, edge index at which the phase was entered, counters
  int m_ph = 0;
  int m_t0 = 0;
  int m_retry = 0;
  int m_loss = 0;
  int k = 0;
  bit eff1 = 0;
  bit eff2 = 0;
  bit prev_rst = 1;

  function automatic logic [OW-1:0] exp_out();
    return {m_ph == 0 || m_ph == 4, m_ph != 3, m_ph == 3,
            m_ph == 4, 3'(m_ph), CW'(m_retry), CW'(m_loss)};
  endfunction

  task automatic model_step(bit r, bit lk, bit rq);
    bit ls;
    int e;
    int nph;
    ls  = prev_rst ? 1'b0 : eff2;
    e   = k - 1 - m_t0;
    nph = m_ph;
    if (r) begin
      m_ph = 0; m_t0 = k; m_retry = 0; m_loss = 0;
    end else begin
      if (rq) begin
        if (m_ph == 4) m_retry = 0;
        nph = 0;
      end else begin
        case (m_ph)
          0: if (e == R - 1) nph = 1;
          1: begin
            if (ls) nph = 2;
            else if (e == LT - 1) begin
              m_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
              nph = (MR != 0 && m_retry >= MR) ? 4 : 0;
            end
          end
          2: begin
            if (!ls) nph = 1;
            else if (e == ST - 1) begin
              nph = 3; m_retry = 0;
            end
          end
          3: if (!ls) begin
            m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
            nph = 0;
          end
          default: ;
        endcase
      end
      if (nph != m_ph || rq) m_t0 = k;
      m_ph = nph;
    end
    eff2 = eff1;
    eff1 = r ? 1'b0 : lk;
    prev_rst = r;
    k++;
  endtask

  task automatic cyc(bit r, bit lk, bit rq);
    @(negedge clk);
    reset = r; locked = lk; relock_req = rq;
    model_step(r, lk, rq);
    expq.push_back(exp_out());
    armed = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic rst2();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
  endtask

  task automatic drop_and_hold(int n);
    cyc(0, 0, 0);
    repeat (n) cyc(0, 1, 0);
  endtask

  initial begin : monitor
    logic [OW-1:0] e;
    logic [OW-1:0] g;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      g = {pll_rst, reset_out, ready, fault, state,
           retry_count, lock_loss_count};
      if (expq.size() == 0) begin
        if (armed) begin
          total++; bad++;
          $display("FAIL sb_underflow: got %h expected none", g);
        end
      end else begin
        e = expq.pop_front();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL sb_cycle t=%0t: got %b expected %b",
                   $time, g, e);
        end
      end
    end
  end

  initial begin : driver
    bit lk;
    int mode;
    // 1: basic sequence and latency
    rst2();
    dchk("rst_outs", {pll_rst, reset_out, ready, fault, state}, 7'b1100000);
    dchk("rst_cnt", {retry_count, lock_loss_count}, 0);
    for (int i = 1; i <= 30; i++) begin
      cyc(0, i >= 11, 0);
      if (i == 3)  dchk("s1_c3_state", state, 0);
      if (i == 4)  dchk("s1_c4_state", state, 1);
      if (i == 20) dchk("s1_c20_ready", ready, 0);
      if (i == 21) dchk("s1_c21_ready", ready, 1);
      if (i == 21) dchk("s1_c21_rstout", reset_out, 0);
    end
    // 2: glitch during STABILIZE
    rst2();
    for (int i = 1; i <= 35; i++) begin
      cyc(0, (i >= 11 && i <= 15) || i >= 18, 0);
      if (i == 27) dchk("s2_c27_ready", ready, 0);
      if (i == 28) dchk("s2_c28_ready", ready, 1);
    end
    dchk("s2_loss", lock_loss_count, 0);
    // 3: timeouts into FAULT, then relock
    rst2();
    for (int i = 1; i <= 115; i++) begin
      cyc(0, 0, 0);
      if (i == 36)  dchk("s3_retry1", retry_count, 1);
      if (i == 72)  dchk("s3_retry2", retry_count, 2);
      if (i == 107) dchk("s3_c107_fault", fault, 0);
      if (i == 108) dchk("s3_fault", fault, 1);
      if (i == 108) dchk("s3_retry3", retry_count, 3);
      if (i == 115) dchk("s3_pllrst", pll_rst, 1);
    end
    cyc(0, 0, 1);
    dchk("s3_relock_state", state, 0);
    dchk("s3_relock_retry", retry_count, 0);
    // 4: single-cycle lock drop in RUN
    repeat (25) cyc(0, 1, 0);
    dchk("s4_run", ready, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    dchk("s4_d1_pllrst", pll_rst, 0);
    cyc(0, 1, 0);
    dchk("s4_d2_pllrst", pll_rst, 1);
    dchk("s4_d2_rstout", reset_out, 1);
    dchk("s4_loss", lock_loss_count, 1);
    repeat (25) cyc(0, 1, 0);
    dchk("s4_rerun", ready, 1);
    // 5: lock-loss counter saturation
    rst2();
    repeat (20) cyc(0, 1, 0);
    for (int j = 0; j < 5; j++) begin
      drop_and_hold(25);
      dchk("s5_loss", lock_loss_count, (j + 1 < 3) ? j + 1 : 3);
    end
    // 6: relock coinciding with RUN lock drop, then reset in STABILIZE
    rst2();
    repeat (20) cyc(0, 1, 0);
    drop_and_hold(25);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    dchk("s6_state", state, 0);
    dchk("s6_loss", lock_loss_count, 1);
    repeat (5) cyc(0, 1, 0);
    dchk("s6_stab", state, 2);
    cyc(1, 1, 0);
    dchk("s6_rst_outs", {pll_rst, reset_out, ready, fault, state}, 7'b1100000);
    dchk("s6_rst_loss", lock_loss_count, 0);
    // randomized traffic
    rst2();
    lk = 0;
    mode = 0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) mode = $urandom_range(0, 2);
      case (mode)
        0: lk = 1'b1;
        1: lk = 1'b0;
        default: if ($urandom_range(0, 5) == 0) lk = ~lk;
      endcase
      cyc($urandom_range(0, 299) == 0, lk,
          $urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    done = 1;
    dchk("sb_drained", expq.size(), 0);
    #100;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
